// File: rtl/fht_pkg.sv
// Shared definitions for the FHT butterfly controller: FSM state encoding,
// default geometry, derived-width helpers and the address bit-reverse helper.
package fht_pkg;

  localparam int unsigned LOG2N_DEF   = 10;
  localparam int unsigned RD_LAT_DEF  = 1;
  localparam int unsigned BUT_LAT_DEF = 2;
  localparam int unsigned WD_DEF      = RD_LAT_DEF + BUT_LAT_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fht_state_e;

  // Width of the stage counter; at least one bit even for tiny transforms.
  function automatic int unsigned stage_w(input int unsigned log2n);
    return (log2n > 32'd2) ? $clog2(log2n) : 32'd1;
  endfunction

  // Write-back delay: memory read latency plus butterfly latency.
  function automatic int unsigned wd_calc(input int unsigned rd_lat, input int unsigned but_lat);
    return rd_lat + but_lat;
  endfunction

  // Reverse the low n bits of v; result is right-aligned, upper bits zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int n);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'd0;
    t = v;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r = {r[30:0], t[0]};
        t = t >> 1'b1;
      end else begin
        r = r;
        t = t;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_but_ctrl_if.sv
// Control/address bundle between the butterfly controller (master) and the
// surrounding top-level FSM, data RAM pair and twiddle ROM (slave side).
interface fht_but_ctrl_if
  import fht_pkg::*;
#(
  parameter int unsigned LOG2N = LOG2N_DEF
);
  localparam int unsigned SW = stage_w(LOG2N);

  logic             iSTART;
  logic             oBUSY;
  logic             oDONE;
  logic [SW-1:0]    oSTAGE;
  logic             oBANK;
  logic             oRD_VAL;
  logic [LOG2N-1:0] oRD_ADDR0;
  logic [LOG2N-1:0] oRD_ADDR1;
  logic [LOG2N-1:0] oRD_ADDR2;
  logic [LOG2N-2:0] oTW_ADDR;
  logic             oWR_EN;
  logic [LOG2N-1:0] oWR_ADDR0;
  logic [LOG2N-1:0] oWR_ADDR1;

  modport master (
    input  iSTART,
    output oBUSY, oDONE, oSTAGE, oBANK, oRD_VAL,
    output oRD_ADDR0, oRD_ADDR1, oRD_ADDR2, oTW_ADDR,
    output oWR_EN, oWR_ADDR0, oWR_ADDR1
  );

  modport slave (
    output iSTART,
    input  oBUSY, oDONE, oSTAGE, oBANK, oRD_VAL,
    input  oRD_ADDR0, oRD_ADDR1, oRD_ADDR2, oTW_ADDR,
    input  oWR_EN, oWR_ADDR0, oWR_ADDR1
  );

endinterface

// File: rtl/fht_wr_dly.sv
// Fixed-depth valid+payload delay line with asynchronous clear. Used to align
// write-back addresses with butterfly results; equally usable for twiddles.
module fht_wr_dly #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DEPTH];
  logic [W-1:0]     dat_d [DEPTH];

  // Shift every stage one position towards the output.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    vld_d[0] = in_vld;
    dat_d[0] = in_dat;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Delay-line registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/fht_but_ctrl.sv
// Operand sequencer and write-back controller for the radix-2 FHT butterfly.
// Walks LOG2N stages of N/2 butterflies over ping-pong banks, then drains the
// pipeline each stage. Optional macro FHT_BITREV_EN bit-reverses the stage-0
// read addresses so natural-order input yields natural-order output.
module fht_but_ctrl
  import fht_pkg::*;
#(
  parameter int unsigned LOG2N   = LOG2N_DEF,
  parameter int unsigned RD_LAT  = RD_LAT_DEF,
  parameter int unsigned BUT_LAT = BUT_LAT_DEF
) (
  input  logic           iCLK,
  input  logic           iRESET,
  fht_but_ctrl_if.master ctl
);

  localparam int unsigned WD = wd_calc(RD_LAT, BUT_LAT);
  localparam int unsigned SW = stage_w(LOG2N);
  localparam int unsigned JW = LOG2N - 1;
  localparam int unsigned DW = (WD > 32'd1) ? $clog2(WD) : 32'd1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [JW-1:0] J_LAST = {JW{1'b1}};
  localparam logic [DW-1:0] D_LAST = DW'(WD - 1);

  fht_state_e    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [JW-1:0] j_q, j_d;
  logic [DW-1:0] dc_q, dc_d;
  logic          bank_q, bank_d;

  logic             rd_val_s;
  logic [LOG2N-1:0] m_s, mask_s, j_ext_s, k_s, base_s;
  logic [LOG2N-1:0] x0_s, x1_s, x2_s;
  logic [LOG2N-1:0] rd0_s, rd1_s, rd2_s;
  logic [JW-1:0]    tw_s;
  logic [2*LOG2N-1:0] wr_din_s, wr_dout_s;
  logic             wr_vld_s;

  // State and counter registers.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      dc_q    <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      dc_q    <= dc_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    dc_d    = dc_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (ctl.iSTART) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          dc_d    = '0;
          bank_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          dc_d    = '0;
        end else begin
          j_d = j_q + JW'(1'b1);
        end
      end
      DRAIN: begin
        if (dc_q == D_LAST) begin
          if (s_q < S_LAST) begin
            state_d = RUN;
            s_d     = s_q + SW'(1'b1);
            bank_d  = ~bank_q;
            j_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          dc_d = dc_q + DW'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Butterfly operand, twiddle and write-back addresses for (s, j).
  always_comb begin
    m_s     = LOG2N'(1'b1) << s_q;
    mask_s  = m_s - LOG2N'(1'b1);
    j_ext_s = LOG2N'(j_q);
    k_s     = j_ext_s & mask_s;
    base_s  = (j_ext_s & ~mask_s) << 1'b1;
    x0_s    = base_s + k_s;
    x1_s    = base_s + m_s + k_s;
    x2_s    = base_s + m_s + ((m_s - k_s) & mask_s);
    tw_s    = JW'(k_s << (SW'(JW) - s_q));
`ifdef FHT_BITREV_EN
    if (s_q == '0) begin
      rd0_s = LOG2N'(bit_rev(32'(x0_s), LOG2N));
      rd1_s = LOG2N'(bit_rev(32'(x1_s), LOG2N));
      rd2_s = LOG2N'(bit_rev(32'(x2_s), LOG2N));
    end else begin
      rd0_s = x0_s;
      rd1_s = x1_s;
      rd2_s = x2_s;
    end
`else
    rd0_s = x0_s;
    rd1_s = x1_s;
    rd2_s = x2_s;
`endif
  end

  assign rd_val_s = (state_q == RUN);
  assign wr_din_s = rd_val_s ? {x0_s, x1_s} : '0;

  fht_wr_dly #(
    .DEPTH (WD),
    .W     (2 * LOG2N)
  ) u_wr_dly (
    .clk     (iCLK),
    .rst     (iRESET),
    .in_vld  (rd_val_s),
    .in_dat  (wr_din_s),
    .out_vld (wr_vld_s),
    .out_dat (wr_dout_s)
  );

  // Output decode; read side is zeroed whenever no butterfly is issued.
  always_comb begin
    ctl.oBUSY     = (state_q != IDLE);
    ctl.oDONE     = (state_q == DONE);
    ctl.oSTAGE    = s_q;
    ctl.oBANK     = bank_q;
    ctl.oRD_VAL   = rd_val_s;
    ctl.oRD_ADDR0 = rd_val_s ? rd0_s : '0;
    ctl.oRD_ADDR1 = rd_val_s ? rd1_s : '0;
    ctl.oRD_ADDR2 = rd_val_s ? rd2_s : '0;
    ctl.oTW_ADDR  = rd_val_s ? tw_s  : '0;
    ctl.oWR_EN    = wr_vld_s;
    ctl.oWR_ADDR0 = wr_dout_s[2*LOG2N-1:LOG2N];
    ctl.oWR_ADDR1 = wr_dout_s[LOG2N-1:0];
  end

endmodule

// File: tb/tb_fht_but_ctrl.sv
// Self-checking bench for fht_but_ctrl at LOG2N=4, RD_LAT=1, BUT_LAT=2.
// Read addresses are compared per cycle against an arithmetic model; expected
// write-backs are queued at issue time and popped when oWR_EN appears.
module tb_fht_but_ctrl;

  localparam int L  = 4;
  localparam int N  = 16;
  localparam int WD = 3;

  logic iCLK = 1'b0;
  logic iRESET;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  logic [7:0] exp_q [$];

  fht_but_ctrl_if #(.LOG2N(L)) bus ();

  fht_but_ctrl #(
    .LOG2N   (L),
    .RD_LAT  (1),
    .BUT_LAT (2)
  ) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .ctl    (bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < L; i++) begin
      if (v[i]) r = r | (1 << (L - 1 - i));
    end
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_rd_val"}, 32'(bus.oRD_VAL), 0);
    chk_eq({tag, "_busy"},   32'(bus.oBUSY), 0);
    chk_eq({tag, "_done"},   32'(bus.oDONE), 0);
    chk_eq({tag, "_stage"},  32'(bus.oSTAGE), 0);
    chk_eq({tag, "_bank"},   32'(bus.oBANK), 0);
    chk_eq({tag, "_rd0"},    32'(bus.oRD_ADDR0), 0);
    chk_eq({tag, "_rd1"},    32'(bus.oRD_ADDR1), 0);
    chk_eq({tag, "_rd2"},    32'(bus.oRD_ADDR2), 0);
    chk_eq({tag, "_tw"},     32'(bus.oTW_ADDR), 0);
    chk_eq({tag, "_wr_en"},  32'(bus.oWR_EN), 0);
    chk_eq({tag, "_wr0"},    32'(bus.oWR_ADDR0), 0);
    chk_eq({tag, "_wr1"},    32'(bus.oWR_ADDR1), 0);
  endtask

  // Scoreboard side: every write-back must match the oldest queued issue.
  always @(negedge iCLK) begin
    logic [7:0] e;
    if (bus.oWR_EN === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk_eq("wr_unexpected", 32'(bus.oWR_EN), 0);
      end else begin
        e = exp_q.pop_front();
        chk_eq("wr_addr0", 32'(bus.oWR_ADDR0), 32'(e[7:4]));
        chk_eq("wr_addr1", 32'(bus.oWR_ADDR1), 32'(e[3:0]));
      end
    end
  end

  // Called at the negedge of the abort cycle: reset mid-transform.
  task automatic reset_mid();
    #2 iRESET = 1'b1;
    #1;
    chk_zero("rst_mid");
    exp_q.delete();
    bus.iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      chk_eq("rst_no_wr", 32'(bus.oWR_EN), 0);
      chk_eq("rst_idle", 32'(bus.oBUSY), 0);
    end
  endtask

  // One transform; cycle 1 is the first cycle after the accepted start.
  task automatic run(input int glitch_at, input int abort_at, input bit start_at_done);
    int c, m, k, base, x0, x1, x2, tw;
    wr_cnt = 0;
    @(negedge iCLK);
    bus.iSTART = 1'b1;
    @(negedge iCLK);
    bus.iSTART = 1'b0;
    c = 1;
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < N / 2 + WD; j++) begin
        if (j < N / 2) begin
          m    = 1 << s;
          k    = j % m;
          base = (j / m) * 2 * m;
          x0   = base + k;
          x1   = base + m + k;
          x2   = base + m + ((m - k) % m);
          tw   = k * ((N / 2) / m);
          exp_q.push_back({4'(x0), 4'(x1)});
`ifdef FHT_BITREV_EN
          if (s == 0) begin
            x0 = brev(x0);
            x1 = brev(x1);
            x2 = brev(x2);
          end
`endif
          chk_eq("rd_val", 32'(bus.oRD_VAL), 1);
          chk_eq("rd_addr0", 32'(bus.oRD_ADDR0), x0);
          chk_eq("rd_addr1", 32'(bus.oRD_ADDR1), x1);
          chk_eq("rd_addr2", 32'(bus.oRD_ADDR2), x2);
          chk_eq("tw_addr", 32'(bus.oTW_ADDR), tw);
        end else begin
          chk_eq("drain_rd_val", 32'(bus.oRD_VAL), 0);
        end
        chk_eq("busy", 32'(bus.oBUSY), 1);
        chk_eq("done_early", 32'(bus.oDONE), 0);
        chk_eq("stage", 32'(bus.oSTAGE), s);
        chk_eq("bank", 32'(bus.oBANK), s % 2);
        bus.iSTART = (c == glitch_at);
        if (c == abort_at) begin
          reset_mid();
          return;
        end
        @(negedge iCLK);
        c++;
      end
    end
    chk_eq("done_pulse", 32'(bus.oDONE), 1);
    chk_eq("done_busy", 32'(bus.oBUSY), 1);
    chk_eq("done_bank", 32'(bus.oBANK), (L - 1) % 2);
    bus.iSTART = start_at_done;
    @(negedge iCLK);
    bus.iSTART = 1'b0;
    chk_eq("done_clear", 32'(bus.oDONE), 0);
    chk_eq("idle_busy", 32'(bus.oBUSY), 0);
    chk_eq("idle_rd_val", 32'(bus.oRD_VAL), 0);
    chk_eq("result_bank", 32'(bus.oBANK), (L - 1) % 2);
    chk_eq("wr_count", wr_cnt, (N / 2) * L);
    chk_eq("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    iRESET = 1'b1;
    bus.iSTART = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    chk_zero("post_reset");
    run(0, 0, 1'b0);
    run(10, 0, 1'b1);
    run(0, 14, 1'b0);
    run(0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fht_but_ctrl.md
Name: fht_but_ctrl

Overview:
- Operand sequencer and write-back controller for the radix-2 FHT butterfly (`fht_but`); drives the butterfly as its initiator.
- For an N-point in-place Hartley transform across ping-pong banks, per stage it generates:
  - three read addresses (x0, x1, x2);
  - the twiddle ROM address;
  - the two write-back addresses, delayed to match the memory plus butterfly pipeline.
- Sits between the top-level FSM, the data RAM pair and the twiddle ROM.

Parameters:
- LOG2N, 10, log2 of transform length N (N = 2^LOG2N, minimum 2).
- RD_LAT, 1, data RAM and twiddle ROM read latency in cycles.
- BUT_LAT, 2, butterfly latency from operands to oY_0/oY_1.

Ports:
- iCLK  in  1  clock
- iRESET  in  1  asynchronous reset, active-high
- iSTART  in  1  one-cycle start pulse; ignored while oBUSY=1
- oBUSY  out  1  high from the cycle after an accepted iSTART through the cycle oDONE is asserted
- oDONE  out  1  one-cycle pulse when all stages are written
- oSTAGE  out  LOG2N bits (clog2 width)  current stage s
- oBANK  out  1  read bank select; write bank = ~oBANK
- oRD_VAL  out  1  read addresses valid this cycle
- oRD_ADDR0  out  LOG2N  x0 address
- oRD_ADDR1  out  LOG2N  x1 address
- oRD_ADDR2  out  LOG2N  x2 address
- oTW_ADDR  out  LOG2N-1  twiddle ROM index; entry i holds cos/sin(2*pi*i/N)
- oWR_EN  out  1  write oY_0/oY_1 this cycle
- oWR_ADDR0  out  LOG2N  destination of oY_0
- oWR_ADDR1  out  LOG2N  destination of oY_1

Behaviour:
- Reset: state IDLE. Every output is 0, including oBANK and the write delay line.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on iSTART. This clears s, j and oBANK.
  - RUN issues one butterfly per cycle, j = 0 .. N/2-1, with oRD_VAL=1. After j = N/2-1 it goes to DRAIN.
  - DRAIN holds oRD_VAL=0 for WD = RD_LAT+BUT_LAT cycles, so the last write lands before the next stage reads.
  - At the end of DRAIN: if s < LOG2N-1, then s+1, oBANK toggles, j=0, go to RUN. Otherwise go to DONE.
  - DONE asserts oDONE for one cycle, then returns to IDLE. oBANK keeps its final value, identifying the result bank.
- Addressing, with M = 2^s, k = j mod M, base = (j >> s) * 2M:
  - x0 = base+k
  - x1 = base+M+k
  - x2 = base+M+((M-k) mod M); for k=0 this gives x2 = base+M
  - tw = k << (LOG2N-1-s)
  - write addresses: W0 = base+k, W1 = base+M+k
- All address arithmetic is unsigned, LOG2N bits, and shift/mask based; no multipliers.
- Write alignment: {W0, W1, valid} enter a WD-deep shift register. oWR_EN/oWR_ADDR* are the register outputs, so a write occurs exactly WD cycles after the matching oRD_VAL.
- Read/address outputs are combinational from the registered counters.
- Timing:
  - Stage cycle count = N/2 + WD.
  - oDONE is asserted LOG2N*(N/2+WD)+1 cycles after the accepted iSTART.
- Boundary conditions:
  - iSTART while busy: ignored.
  - iSTART coincident with oDONE: ignored; the block accepts it from IDLE only.
  - iRESET mid-transform: asynchronous return to IDLE; pending writes are discarded (oWR_EN=0 immediately).

Optional Feature:
- Macro: FHT_BITREV_EN.
- Defined: in stage 0 only, oRD_ADDR0/1/2 are bit-reversed over LOG2N bits. Natural-order input then produces natural-order output. Write addresses are unchanged.
- Undefined: the input must already be in bit-reversed order; all addresses follow the formulas above.

Decomposition:
- Shared package fht_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the LOG2N-derived widths;
  - the WD localparam;
  - the bit-reverse function.
- Sub-module fht_wr_dly: a parameterised WD-deep valid+address shift register with asynchronous reset. Reusable for twiddle alignment.

Test Plan (LOG2N=4, RD_LAT=1, BUT_LAT=2, macro off unless stated):
- Stage 0, j=0 -> x0=0, x1=1, x2=1, tw=0; oWR_EN 3 cycles later with W0=0, W1=1.
- Stage 2, j=1 -> x0=1, x1=5, x2=7, tw=2; stage 3, j=3 -> x0=3, x1=11, x2=13, tw=3.
- Full run: iSTART at cycle 0 -> oBUSY from cycle 1; oDONE at cycle 45; oBANK toggles 3 times; exactly 32 oWR_EN pulses; no oRD_VAL during DRAIN.
- iSTART pulsed at cycle 10 of a run -> ignored; oDONE still at cycle 45; second iSTART after oDONE restarts at s=0.
- iRESET asserted mid stage 1 -> all outputs 0 in the same cycle, no further oWR_EN; after release, iSTART gives a clean full run.
- FHT_BITREV_EN defined, stage 0, j=1 -> x0=4, x1=12, x2=12; stage 1 addresses match the macro-off case.
